// File: rtl/bram_2k_x8.sv
// Single-port 2K x 8 block RAM slice with registered, read-first output.
// Optional BRAM_PARITY_EN stores an even-parity bit per word and adds the PERR output.
module bram_2k_x8 #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              EN,
    input  logic              WE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
`ifdef BRAM_PARITY_EN
    ,
    output logic              PERR
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;
`ifdef BRAM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    // The array has no reset so it maps onto block RAM.
    logic [MEM_W-1:0] mem [DEPTH];
    logic [MEM_W-1:0] wr_word;

    always_comb begin
`ifdef BRAM_PARITY_EN
        wr_word = {^data_in, data_in};
`else
        wr_word = data_in;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST_N && EN && WE) begin
            mem[ADDR] <= wr_word;
        end
    end

    // The read samples the pre-write contents, which gives read-first behaviour.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            data_out <= '0;
`ifdef BRAM_PARITY_EN
            PERR     <= 1'b0;
`endif
        end else if (EN) begin
            data_out <= mem[ADDR][DATA_W-1:0];
`ifdef BRAM_PARITY_EN
            PERR     <= ^mem[ADDR];
`endif
        end
    end

endmodule

// File: tb/tb_bram_2k_x8.sv
// Directed self-checking bench for bram_2k_x8 (parity checks when BRAM_PARITY_EN is defined).
module tb_bram_2k_x8;

    logic        CLK;
    logic        RST_N;
    logic        EN;
    logic        WE;
    logic [10:0] ADDR;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
`ifdef BRAM_PARITY_EN
    logic        perr;
`endif

    int total = 0;
    int bad   = 0;

    bram_2k_x8 #(.ADDR_W(11), .DATA_W(8)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .EN       (EN),
        .WE       (WE),
        .ADDR     (ADDR),
        .data_in  (data_in),
        .data_out (data_out)
`ifdef BRAM_PARITY_EN
        ,
        .PERR     (perr)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drive one access at the falling edge, then settle just past the rising edge.
    task automatic cyc(input logic en, input logic we, input logic [10:0] a, input logic [7:0] d);
        @(negedge CLK);
        EN      = en;
        WE      = we;
        ADDR    = a;
        data_in = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        RST_N   = 1'b0;
        EN      = 1'b0;
        WE      = 1'b0;
        ADDR    = '0;
        data_in = '0;
        #2;
        chk("reset_init", data_out, 8'h00);
`ifdef BRAM_PARITY_EN
        chk("reset_perr", {7'd0, perr}, 8'h00);
`endif
        @(negedge CLK);
        RST_N = 1'b1;

        // Basic write/read including both address extremes and the midpoint
        cyc(1'b1, 1'b1, 11'h000, 8'hA5);
        cyc(1'b1, 1'b1, 11'h7FF, 8'h3C);
        cyc(1'b1, 1'b1, 11'h400, 8'h01);
        cyc(1'b1, 1'b0, 11'h000, 8'h00);
        chk("rd_000", data_out, 8'hA5);
        cyc(1'b1, 1'b0, 11'h7FF, 8'h00);
        chk("rd_7ff", data_out, 8'h3C);
        cyc(1'b1, 1'b0, 11'h400, 8'h00);
        chk("rd_400", data_out, 8'h01);

        // No aliasing between 3FF and 7FF
        cyc(1'b1, 1'b1, 11'h3FF, 8'h5A);
        cyc(1'b1, 1'b0, 11'h7FF, 8'h00);
        chk("noalias_7ff", data_out, 8'h3C);
        cyc(1'b1, 1'b0, 11'h3FF, 8'h00);
        chk("rd_3ff", data_out, 8'h5A);

        // Back-to-back pipelined reads
        cyc(1'b1, 1'b1, 11'd0, 8'h10);
        cyc(1'b1, 1'b1, 11'd1, 8'h11);
        cyc(1'b1, 1'b1, 11'd2, 8'h12);
        cyc(1'b1, 1'b1, 11'd3, 8'h13);
        cyc(1'b1, 1'b0, 11'd0, 8'h00);
        chk("pipe_0", data_out, 8'h10);
        cyc(1'b1, 1'b0, 11'd1, 8'h00);
        chk("pipe_1", data_out, 8'h11);
        cyc(1'b1, 1'b0, 11'd2, 8'h00);
        chk("pipe_2", data_out, 8'h12);
        cyc(1'b1, 1'b0, 11'd3, 8'h00);
        chk("pipe_3", data_out, 8'h13);

        // Asynchronous reset between edges, stored data survives
        cyc(1'b1, 1'b0, 11'h7FF, 8'h00);
        chk("pre_reset_rd", data_out, 8'h3C);
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_reset", data_out, 8'h00);
        @(negedge CLK);
        RST_N = 1'b1;
        cyc(1'b1, 1'b0, 11'h7FF, 8'h00);
        chk("post_reset_rd", data_out, 8'h3C);

        // Read-during-write returns old data
        cyc(1'b1, 1'b1, 11'd5, 8'h22);
        cyc(1'b1, 1'b1, 11'd5, 8'h77);
        chk("rdw_old", data_out, 8'h22);
        cyc(1'b1, 1'b0, 11'd5, 8'h00);
        chk("rdw_new", data_out, 8'h77);

        // EN low blocks writes and holds the output
        cyc(1'b1, 1'b0, 11'd0, 8'h00);
        chk("pre_hold_rd", data_out, 8'h10);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 11'd5, 8'hFF);
            chk($sformatf("en0_hold_%0d", i), data_out, 8'h10);
        end
        cyc(1'b1, 1'b0, 11'd5, 8'h00);
        chk("en0_nowrite", data_out, 8'h77);

`ifdef BRAM_PARITY_EN
        cyc(1'b1, 1'b1, 11'd9, 8'h07);
        cyc(1'b1, 1'b0, 11'd9, 8'h00);
        chk("par_ok_data", data_out, 8'h07);
        chk("par_ok_perr", {7'd0, perr}, 8'h00);
        @(negedge CLK);
        dut.mem[9][8] = ~dut.mem[9][8];
        cyc(1'b1, 1'b0, 11'd9, 8'h00);
        chk("par_bad_data", data_out, 8'h07);
        chk("par_bad_perr", {7'd0, perr}, 8'h01);
        cyc(1'b1, 1'b0, 11'd0, 8'h00);
        chk("par_clean_perr", {7'd0, perr}, 8'h00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
